// File: rtl/seq_mult_ctrl_taint_pkg.sv
// Shared types and helpers for the taint-tracking sequential multiplier controller.
package seq_mult_ctrl_taint_pkg;

  localparam int unsigned PHASE_W = 3;

  typedef enum logic [PHASE_W-1:0] {
    PH_IDLE  = 3'd0,
    PH_INIT  = 3'd1,
    PH_TEST  = 3'd2,
    PH_ADD   = 3'd3,
    PH_SHIFT = 3'd4,
    PH_DONE  = 3'd5
  } phase_e;

  // Bit counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_mult_ctrl_taint_taint_state_reg.sv
// One-bit sticky taint register: reset, then kill, then clear, then OR-accumulate set.
module taint_state_reg (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic kill,
  input  logic clear,
  output logic q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= 1'b0;
    end else if (kill) begin
      q <= 1'b0;
    end else if (clear) begin
      q <= 1'b0;
    end else begin
      q <= q | set;
    end
  end

endmodule

// File: rtl/seq_mult_ctrl_taint.sv
// Shift-add multiplier controller: phase register plus bit counter, with state taint tracking.
module seq_mult_ctrl_taint
  import seq_mult_ctrl_taint_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter bit          CONST_TIME  = 1'b0,
  parameter bit          RECONV_KILL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             start_t,
  input  logic             state_t_kill,
  input  logic [WIDTH-1:0] multiplierReg,
  input  logic [WIDTH-1:0] multiplierReg_t,
  output logic             mdld,
  output logic             mrld,
  output logic             rsclear,
  output logic             rsload,
  output logic             rsshr,
  output logic             busy,
  output logic             productDone,
  output logic             mdld_t,
  output logic             mrld_t,
  output logic             rsclear_t,
  output logic             rsload_t,
  output logic             rsshr_t,
  output logic             busy_t,
  output logic             productDone_t,
  output logic             state_t
);

  localparam int unsigned      CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  phase_e           phase;
  phase_e           phase_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             taint_set;
  logic             taint_clear;

  // Next phase, bit counter and taint set/clear sources.
  always_comb begin
    phase_nxt   = phase;
    cnt_nxt     = cnt;
    taint_set   = 1'b0;
    taint_clear = 1'b0;
    case (phase)
      PH_IDLE: begin
        taint_set = start_t;
        if (start) phase_nxt = PH_INIT;
      end
      PH_INIT: begin
        cnt_nxt   = '0;
        phase_nxt = CONST_TIME ? PH_ADD : PH_TEST;
      end
      PH_TEST: begin
        // The branch taken depends on the multiplier bit, so its taint leaks into state.
        taint_set = multiplierReg_t[cnt];
        phase_nxt = multiplierReg[cnt] ? PH_ADD : PH_SHIFT;
      end
      PH_ADD: begin
        phase_nxt = PH_SHIFT;
      end
      PH_SHIFT: begin
        if (cnt == CNT_LAST) begin
          phase_nxt = PH_DONE;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
          phase_nxt = CONST_TIME ? PH_ADD : PH_TEST;
        end
      end
      PH_DONE: begin
        taint_clear = RECONV_KILL;
        phase_nxt   = PH_IDLE;
      end
      default: begin
        phase_nxt = PH_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase <= PH_IDLE;
      cnt   <= '0;
    end else begin
      phase <= phase_nxt;
      cnt   <= cnt_nxt;
    end
  end

  taint_state_reg u_state_taint (
    .clk   (clk),
    .rst   (rst),
    .set   (taint_set),
    .kill  (state_t_kill),
    .clear (taint_clear),
    .q     (state_t)
  );

  // Strobe decode; every strobe inherits state taint, even while low.
  always_comb begin
    mdld          = 1'b0;
    mrld          = 1'b0;
    rsclear       = 1'b0;
    rsload        = 1'b0;
    rsshr         = 1'b0;
    productDone   = 1'b0;
    busy          = (phase != PH_IDLE);
    mdld_t        = state_t;
    mrld_t        = state_t;
    rsclear_t     = state_t;
    rsload_t      = state_t;
    rsshr_t       = state_t;
    busy_t        = state_t;
    productDone_t = state_t;
    case (phase)
      PH_INIT: begin
        mdld    = 1'b1;
        mrld    = 1'b1;
        rsclear = 1'b1;
      end
      PH_ADD: begin
        if (CONST_TIME) begin
          // Data-dependent gating keeps timing constant; taint moves onto rsload only.
          rsload   = multiplierReg[cnt];
          rsload_t = multiplierReg_t[cnt] | state_t;
        end else begin
          rsload = 1'b1;
        end
      end
      PH_SHIFT: rsshr       = 1'b1;
      PH_DONE:  productDone = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq_mult_ctrl_taint.sv
// Bench for seq_mult_ctrl_taint: three configurations checked against a schedule-based model.
module tb_seq_mult_ctrl_taint;

  localparam int unsigned W  = 4;
  localparam int          NI = 3;
  localparam int K_IDLE = 0, K_INIT = 1, K_TEST = 2, K_ADD = 3, K_SHIFT = 4, K_DONE = 5;

  logic         clk = 1'b0;
  logic         rst, start, start_t, state_t_kill;
  logic [W-1:0] mreg, mreg_t;
  logic mdld [NI], mrld [NI], rsclear [NI], rsload [NI], rsshr [NI], busy [NI], pdone [NI];
  logic mdld_t [NI], mrld_t [NI], rsclear_t [NI], rsload_t [NI], rsshr_t [NI], busy_t [NI];
  logic pdone_t [NI], state_t [NI];

  always #5 clk = ~clk;

  // u0: data-dependent, reconvergence kill; u1: constant time; u2: no reconvergence kill
  seq_mult_ctrl_taint #(.WIDTH(W), .CONST_TIME(1'b0), .RECONV_KILL(1'b1)) u0 (
    .clk(clk), .rst(rst), .start(start), .start_t(start_t), .state_t_kill(state_t_kill),
    .multiplierReg(mreg), .multiplierReg_t(mreg_t),
    .mdld(mdld[0]), .mrld(mrld[0]), .rsclear(rsclear[0]), .rsload(rsload[0]), .rsshr(rsshr[0]),
    .busy(busy[0]), .productDone(pdone[0]), .mdld_t(mdld_t[0]), .mrld_t(mrld_t[0]),
    .rsclear_t(rsclear_t[0]), .rsload_t(rsload_t[0]), .rsshr_t(rsshr_t[0]), .busy_t(busy_t[0]),
    .productDone_t(pdone_t[0]), .state_t(state_t[0]));

  seq_mult_ctrl_taint #(.WIDTH(W), .CONST_TIME(1'b1), .RECONV_KILL(1'b1)) u1 (
    .clk(clk), .rst(rst), .start(start), .start_t(start_t), .state_t_kill(state_t_kill),
    .multiplierReg(mreg), .multiplierReg_t(mreg_t),
    .mdld(mdld[1]), .mrld(mrld[1]), .rsclear(rsclear[1]), .rsload(rsload[1]), .rsshr(rsshr[1]),
    .busy(busy[1]), .productDone(pdone[1]), .mdld_t(mdld_t[1]), .mrld_t(mrld_t[1]),
    .rsclear_t(rsclear_t[1]), .rsload_t(rsload_t[1]), .rsshr_t(rsshr_t[1]), .busy_t(busy_t[1]),
    .productDone_t(pdone_t[1]), .state_t(state_t[1]));

  seq_mult_ctrl_taint #(.WIDTH(W), .CONST_TIME(1'b0), .RECONV_KILL(1'b0)) u2 (
    .clk(clk), .rst(rst), .start(start), .start_t(start_t), .state_t_kill(state_t_kill),
    .multiplierReg(mreg), .multiplierReg_t(mreg_t),
    .mdld(mdld[2]), .mrld(mrld[2]), .rsclear(rsclear[2]), .rsload(rsload[2]), .rsshr(rsshr[2]),
    .busy(busy[2]), .productDone(pdone[2]), .mdld_t(mdld_t[2]), .mrld_t(mrld_t[2]),
    .rsclear_t(rsclear_t[2]), .rsload_t(rsload_t[2]), .rsshr_t(rsshr_t[2]), .busy_t(busy_t[2]),
    .productDone_t(pdone_t[2]), .state_t(state_t[2]));

  // Model: each operation is a precomputed list of steps; taint is a sticky bit.
  int m_kind [NI][64];
  int m_bit  [NI][64];
  int m_len  [NI];
  int m_pos  [NI];
  bit m_act  [NI];
  bit m_t    [NI];

  int n_chk, n_pass, cyc;
  int done0, done1, n_done0, n_rl0, n_sh0, n_md0, n_anyt0, n_rlt1, n_st1, rise0;

  function automatic bit ct_of(input int i);
    return i == 1;
  endfunction

  function automatic bit rk_of(input int i);
    return i != 2;
  endfunction

  function automatic int cur_kind(input int i);
    return m_act[i] ? m_kind[i][m_pos[i]] : K_IDLE;
  endfunction

  function automatic int cur_bit(input int i);
    return m_act[i] ? m_bit[i][m_pos[i]] : 0;
  endfunction

  task automatic build(input int i);
    int n;
    n = 0;
    m_kind[i][n] = K_INIT; m_bit[i][n] = 0; n++;
    for (int b = 0; b < int'(W); b++) begin
      if (!ct_of(i)) begin m_kind[i][n] = K_TEST; m_bit[i][n] = b; n++; end
      if (ct_of(i) || mreg[b]) begin m_kind[i][n] = K_ADD; m_bit[i][n] = b; n++; end
      m_kind[i][n] = K_SHIFT; m_bit[i][n] = b; n++;
    end
    m_kind[i][n] = K_DONE; m_bit[i][n] = 0; n++;
    m_len[i] = n;
    m_pos[i] = 0;
    m_act[i] = 1'b1;
  endtask

  task automatic model_edge(input int i);
    int  k;
    bit  set, clr;
    k   = cur_kind(i);
    set = (k == K_IDLE && start_t) || (k == K_TEST && mreg_t[cur_bit(i)]);
    clr = (k == K_DONE) && rk_of(i);
    if (!rst) begin
      m_t[i]   = 1'b0;
      m_act[i] = 1'b0;
    end else begin
      m_t[i] = state_t_kill ? 1'b0 : (clr ? 1'b0 : (m_t[i] | set));
      if (k == K_IDLE) begin
        if (start) build(i);
      end else if (m_pos[i] + 1 == m_len[i]) begin
        m_act[i] = 1'b0;
      end else begin
        m_pos[i]++;
      end
    end
  endtask

  function automatic logic [14:0] expv(input int i);
    int   k, b;
    logic t, rl, rlt;
    k   = cur_kind(i);
    b   = cur_bit(i);
    t   = m_t[i];
    rl  = (k == K_ADD) && (ct_of(i) ? mreg[b] : 1'b1);
    rlt = (k == K_ADD && ct_of(i)) ? (mreg_t[b] | t) : t;
    return {k == K_INIT, k == K_INIT, k == K_INIT, rl, k == K_SHIFT, k != K_IDLE, k == K_DONE,
            t, t, t, rlt, t, t, t, t};
  endfunction

  function automatic logic [14:0] obs(input int i);
    return {mdld[i], mrld[i], rsclear[i], rsload[i], rsshr[i], busy[i], pdone[i],
            mdld_t[i], mrld_t[i], rsclear_t[i], rsload_t[i], rsshr_t[i], busy_t[i],
            pdone_t[i], state_t[i]};
  endfunction

  task automatic check_lit(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
  endtask

  task automatic clear_stats();
    done0 = -1; done1 = -1; n_done0 = 0; n_rl0 = 0; n_sh0 = 0; n_md0 = 0;
    n_anyt0 = 0; n_rlt1 = 0; n_st1 = 0; rise0 = -1;
  endtask

  // One clock: advance the model, then compare every DUT against it.
  task automatic step();
    bit          starting;
    logic [14:0] o, e;
    starting = rst && start && !m_act[0];
    for (int i = 0; i < NI; i++) model_edge(i);
    @(posedge clk);
    #1;
    cyc = starting ? 1 : cyc + 1;
    for (int i = 0; i < NI; i++) begin
      o = obs(i);
      e = expv(i);
      n_chk++;
      if (o === e) n_pass++;
      else $display("FAIL dut%0d_outputs cyc=%0d got=%b want=%b t=%0t", i, cyc, o, e, $time);
    end
    o = obs(0);
    if (pdone[0]) begin done0 = cyc; n_done0++; end
    if (pdone[1]) done1 = cyc;
    if (state_t[0] && rise0 < 0) rise0 = cyc;
    n_rl0   += int'(rsload[0]);
    n_sh0   += int'(rsshr[0]);
    n_md0   += int'(mdld[0]);
    n_anyt0 += int'(|o[7:0]);
    n_rlt1  += int'(rsload_t[1]);
    n_st1   += int'(state_t[1]);
  endtask

  task automatic run_idle();
    int guard;
    guard = 0;
    while ((m_act[0] || m_act[1] || m_act[2]) && guard < 60) begin
      step();
      guard++;
    end
    check_lit("run_completes_in_budget", int'(guard < 60), 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic kill_taint();
    state_t_kill = 1'b1;
    step();
    state_t_kill = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0;
    for (int i = 0; i < NI; i++) begin
      m_act[i] = 1'b0; m_t[i] = 1'b0; m_pos[i] = 0; m_len[i] = 0;
    end
    clear_stats();
    rst = 1'b0; start = 1'b0; start_t = 1'b0; state_t_kill = 1'b0;
    mreg = '0; mreg_t = '0;

    // Reset
    step(); step();
    check_lit("reset_outputs_dut0", int'(obs(0)), 0);
    rst = 1'b1;
    step();

    // Untainted data-dependent and constant-time runs
    mreg = 4'b1011; mreg_t = 4'b0000;
    clear_stats();
    pulse_start();
    run_idle();
    check_lit("ct0_done_cycle", done0, 13);
    check_lit("ct0_rsload_pulses", n_rl0, 3);
    check_lit("ct0_rsshr_pulses", n_sh0, 4);
    check_lit("ct0_no_taint", n_anyt0, 0);
    check_lit("ct1_done_cycle", done1, 10);

    // Constant-time taint stays on rsload only
    mreg_t = 4'b0100;
    clear_stats();
    pulse_start();
    run_idle();
    check_lit("ct1_done_cycle_tainted", done1, 10);
    check_lit("ct1_rsload_t_cycles", n_rlt1, 1);
    check_lit("ct1_state_t_cycles", n_st1, 0);
    check_lit("reconv_kill_idle_state_t", int'(state_t[0]), 0);
    check_lit("no_reconv_idle_state_t", int'(state_t[2]), 1);
    mreg_t = 4'b0000;
    kill_taint();
    check_lit("kill_clears_state_t", int'(state_t[2]), 0);

    // Taint from the bit-1 test
    mreg_t = 4'b0010;
    clear_stats();
    pulse_start();
    run_idle();
    check_lit("bit1_taint_rise_cycle", rise0, 6);
    check_lit("bit1_reconv_idle", int'(state_t[0]), 0);
    check_lit("bit1_no_reconv_idle", int'(state_t[2]), 1);
    mreg_t = 4'b0000;
    kill_taint();

    // start_t in IDLE, and kill winning over a set source
    start_t = 1'b1;
    step();
    check_lit("idle_start_t_sets", int'(state_t[0]), 1);
    state_t_kill = 1'b1;
    step();
    step();
    check_lit("kill_beats_start_t", int'(state_t[0]), 0);
    state_t_kill = 1'b0; start_t = 1'b0;
    step();

    // Reset during the third SHIFT, then a clean run
    mreg = 4'b1011;
    clear_stats();
    pulse_start();
    for (int s = 0; s < 8; s++) step();
    check_lit("third_shift_cycle", int'(rsshr[0]), 1);
    check_lit("third_shift_cyc_index", cyc, 9);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check_lit("midop_reset_outputs", int'(obs(0)), 0);
    check_lit("midop_reset_no_done", n_done0, 0);
    clear_stats();
    pulse_start();
    run_idle();
    check_lit("after_reset_done_cycle", done0, 13);

    // start/start_t held high: one op, then back-to-back restart
    clear_stats();
    start = 1'b1; start_t = 1'b1;
    for (int s = 0; s < 20; s++) step();
    check_lit("held_start_init_count", n_md0, 2);
    check_lit("held_start_done_count", n_done0, 1);
    check_lit("held_start_done_cycle", done0, 13);
    start = 1'b0; start_t = 1'b0;
    run_idle();
    kill_taint();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_mult_ctrl_taint.md
# seq_mult_ctrl_taint

Parametrised control FSM for the shift-add sequential multiplier with taint tracking. It is the successor to the bit-indexed multiplier controller and drives the same datapath strobes (mdld, mrld, rsclear, rsload, rsshr). It replaces the per-bit state encoding with a phase register plus a bit counter. It adds a constant-time mode, reconvergence-based taint clearing, explicit busy/done signalling, and fully defined taint on every output.

## Interface
- WIDTH, 32: multiplier operand width; legal values ≥ 2.
- CONST_TIME, 0: 1 = every bit takes an ADD cycle, and rsload is gated by the multiplier bit.
- RECONV_KILL, 1: 1 = state taint clears when DONE returns to IDLE.
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset; 0 at a rising clk edge resets.
- start  in  1  request a multiply; sampled only in IDLE.
- start_t  in  1  taint of start.
- state_t_kill  in  1  forces state taint to 0 at the next edge.
- multiplierReg  in  WIDTH  multiplier register contents from the datapath.
- multiplierReg_t  in  WIDTH  per-bit taint of multiplierReg.
- mdld, mrld, rsclear  out  1  load multiplicand, load multiplier, clear result; asserted in INIT.
- rsload  out  1  add the multiplicand into the result register.
- rsshr  out  1  shift the result register right.
- busy  out  1  high in every state except IDLE.
- productDone  out  1  one-cycle pulse in DONE.
- *_t for each of the seven outputs above  out  1  taint of that output.
- state_t  out  1  current state taint; covers both phase and counter.

## Operation
- Phases: IDLE, INIT, TEST, ADD, SHIFT, DONE. Counter cnt has width max(1, $clog2(WIDTH)).
- IDLE
  - start=1 → INIT; otherwise stay in IDLE.
  - start_t=1 sets state_t, whatever the value of start.
- INIT
  - Asserts mdld, mrld and rsclear; cnt ← 0.
  - Next phase: TEST if CONST_TIME=0, ADD if CONST_TIME=1.
- TEST (CONST_TIME=0 only)
  - No strobes.
  - multiplierReg[cnt]=1 → ADD; otherwise → SHIFT.
  - multiplierReg_t[cnt]=1 sets state_t.
- ADD
  - CONST_TIME=0: rsload=1.
  - CONST_TIME=1: rsload=multiplierReg[cnt]; rsload_t = multiplierReg_t[cnt] | state_t; state_t is not set from multiplier taint.
  - Next phase: SHIFT.
- SHIFT
  - rsshr=1.
  - cnt==WIDTH-1 → DONE. Otherwise cnt+1, then TEST (CONST_TIME=0) or ADD (CONST_TIME=1).
- DONE
  - productDone=1 → IDLE.
  - RECONV_KILL=1 clears state_t on this transition.
- Output taint
  - Every *_t equals state_t, in every phase, including while the output is 0 (except rsload_t in CONST_TIME=1, defined above).
  - No output taint is left undriven.
- Taint update precedence, highest first:
  1. rst=0 → 0.
  2. state_t_kill=1 → 0.
  3. RECONV_KILL clear on DONE→IDLE → 0.
  4. Sticky OR of the set sources.
- start and start_t are ignored while busy and do not set taint.

## Timing
- Reset
  - Phase IDLE, cnt 0, state_t 0.
  - All strobes, busy and productDone are 0; all *_t outputs are 0.
- Start edge = cycle 0; INIT occupies cycle 1.
- CONST_TIME=0: DONE occurs at cycle 2 + 2·WIDTH + popcount(multiplierReg).
- CONST_TIME=1: DONE occurs at cycle 2 + 2·WIDTH, independent of the data.
- IDLE is re-entered the cycle after DONE; a new start is accepted in that IDLE cycle.
- state_t_kill takes effect at the next edge. If a set source is active in the same cycle, the kill wins.
- rst=0 mid-operation: IDLE at the next edge; no productDone pulse.
- multiplierReg must stay stable from INIT+1 until DONE. The controller does not latch it.

## Structure
- Shared package holds:
  - the phase enum (IDLE=0, INIT=1, TEST=2, ADD=3, SHIFT=4, DONE=5);
  - the phase width constant (3);
  - the counter width function.
- Sub-module taint_state_reg: a 1-bit sticky taint register with kill and clear inputs and the precedence defined above. It is reusable by the datapath taint logic.
- Two always blocks: next-phase/counter/taint logic and the output decode; one sequential block.

## Test plan
- WIDTH=4, CONST_TIME=0, multiplierReg=4'b1011, no taint → productDone at cycle 13; rsload pulses 3 times; rsshr pulses 4 times; every *_t stays 0.
- WIDTH=4, CONST_TIME=1, multiplierReg=4'b1011, multiplierReg_t=4'b0100 → productDone at cycle 10; rsload_t=1 only in the ADD for bit 2; state_t stays 0.
- WIDTH=4, CONST_TIME=0, multiplierReg_t[1]=1
  - state_t rises after the bit-1 TEST, and every *_t is 1 from then until DONE.
  - state_t is 0 in the following IDLE when RECONV_KILL=1; it remains 1 when RECONV_KILL=0.
- start=0 with start_t=1 in IDLE → state_t=1 next cycle. Assert state_t_kill together with start_t → state_t stays 0.
- rst=0 during the third SHIFT → IDLE, cnt=0, all outputs 0 next cycle. A later start completes with the correct timing.
- start and start_t held at 1 throughout a run → exactly one operation; no taint from start_t after IDLE; back-to-back restart at the IDLE cycle after DONE.
